vga_line_fetch: RTL and testbench

Line-prefetch stage directly upstream of the VGA timing/pixel generator. While line N is displayed, it fetches line N+1 of a 12-bit framebuffer from a read-only memory port into one half of a ping-pong line buffer. It then returns the pixel for the current beam position to the timing generator. It also flags any fetch that misses its line deadline.

---
 rtl/vga_line_fetch.sv | 137 +++++++++++++
 tb/tb_vga_line_fetch.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch.sv
// Line prefetcher for the VGA pixel path: fills one half of a ping-pong line buffer
// from a read-only memory port while the other half is displayed.
module vga_line_fetch #(
    parameter int          SCREEN_WIDTH  = 640,
    parameter int          SCREEN_HEIGHT = 480,
    parameter int          V_TOTAL       = 525,
    parameter int          PIX_W         = 12,
    parameter int          ADDR_W        = 20,
    parameter int unsigned FB_BASE       = 0,
    parameter int          MAX_OUTST     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       pix_x,
    input  logic [15:0]       pix_y,
    input  logic              pix_active,
    output logic [PIX_W-1:0]  pix_out,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ready,
    input  logic              rd_valid,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              busy,
    output logic              underrun_err,
    output logic              overrun_err
);

    localparam int CNT_W = $clog2(SCREEN_WIDTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam int IDX_W = $clog2(2 * SCREEN_WIDTH);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             state, state_nxt;
    logic [15:0]        fetch_line;
    logic [15:0]        trig_line;
    logic [CNT_W-1:0]   issue_cnt, recv_cnt;
    logic [OUT_W-1:0]   outst;
    logic [1:0]         bank_valid;
    logic               trig, accept, wr_en, last_wr, pix_in;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic [PIX_W-1:0]   line_mem [2*SCREEN_WIDTH];
    logic [PIX_W-1:0]   pix_p1;
    logic               vld_p1;

    // Line N+1 is requested at the start of line N; the last blanking line requests line 0.
    assign trig      = (pix_x == 16'd0) &&
                       ((pix_y < 16'(SCREEN_HEIGHT - 1)) || (pix_y == 16'(V_TOTAL - 1)));
    assign trig_line = (pix_y == 16'(V_TOTAL - 1)) ? 16'd0 : pix_y + 16'd1;

    assign accept  = rd_req && rd_ready;
    assign wr_en   = (state == FETCH) && rd_valid && (recv_cnt < CNT_W'(SCREEN_WIDTH));
    assign last_wr = wr_en && (recv_cnt == CNT_W'(SCREEN_WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        unique case (state)
            IDLE: begin
                if (trig) state_nxt = FETCH;
            end
            FETCH: begin
                busy    = 1'b1;
                rd_req  = (issue_cnt < CNT_W'(SCREEN_WIDTH)) && (outst < OUT_W'(MAX_OUTST));
                rd_addr = ADDR_W'(FB_BASE) + ADDR_W'(fetch_line) * ADDR_W'(SCREEN_WIDTH)
                        + ADDR_W'(issue_cnt);
                if (last_wr) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_line  <= '0;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            outst       <= '0;
            bank_valid  <= 2'b00;
            overrun_err <= 1'b0;
        end else if (state == IDLE) begin
            if (trig) begin
                fetch_line               <= trig_line;
                issue_cnt                <= '0;
                recv_cnt                 <= '0;
                outst                    <= '0;
                bank_valid[trig_line[0]] <= 1'b0;
            end
        end else begin
            if (accept) issue_cnt <= issue_cnt + CNT_W'(1);
            if (wr_en)  recv_cnt  <= recv_cnt + CNT_W'(1);
            // A same-cycle accept and return leaves the outstanding count unchanged.
            unique case ({accept, wr_en})
                2'b10:   outst <= outst + OUT_W'(1);
                2'b01:   outst <= outst - OUT_W'(1);
                default: outst <= outst;
            endcase
            if (last_wr) bank_valid[fetch_line[0]] <= 1'b1;
            if (trig)    overrun_err <= 1'b1;
        end
    end

    assign wr_idx = IDX_W'(recv_cnt) + (fetch_line[0] ? IDX_W'(SCREEN_WIDTH) : IDX_W'(0));

    always_ff @(posedge clk) begin
        if (wr_en) line_mem[wr_idx] <= rd_data;
    end

    assign pix_in = pix_x < 16'(SCREEN_WIDTH);
    assign rd_idx = (pix_in ? IDX_W'(pix_x) : IDX_W'(0))
                  + (pix_y[0] ? IDX_W'(SCREEN_WIDTH) : IDX_W'(0));

    // p1: buffer read registered; the valid flag gates it to black outside valid pixels.
    always_ff @(posedge clk) begin
        pix_p1 <= line_mem[rd_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1       <= 1'b0;
            underrun_err <= 1'b0;
        end else begin
            vld_p1 <= pix_active && bank_valid[pix_y[0]] && pix_in;
            if (pix_active && !bank_valid[pix_y[0]]) underrun_err <= 1'b1;
        end
    end

    assign pix_out = vld_p1 ? pix_p1 : '0;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch on a reduced screen geometry with a behavioural
// in-order memory whose data is the low 12 bits of the requested address.
module tb_vga_line_fetch;

    localparam int W  = 16;
    localparam int H  = 6;
    localparam int VT = 9;
    localparam int HT = 48;
    localparam int PW = 12;
    localparam int AW = 20;
    localparam int MO = 4;
    localparam int FB = 'h100;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [15:0]   pix_x = '0, pix_y = '0;
    logic          pix_active = 1'b0;
    logic [PW-1:0] pix_out;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready = 1'b0, rd_valid = 1'b0;
    logic [PW-1:0] rd_data = '0;
    logic          busy, underrun_err, overrun_err;

    vga_line_fetch #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .V_TOTAL(VT), .PIX_W(PW),
        .ADDR_W(AW), .FB_BASE(FB), .MAX_OUTST(MO)
    ) dut (
        .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
        .pix_out(pix_out), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
        .underrun_err(underrun_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int due; } req_t;
    typedef struct { int x; int y; bit busy; int addr; } vec_t;

    req_t q[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, lat = 1, rmode = 0;
    int   beam_x = 0, beam_y = 0, frame = 0;
    bit   beam_run = 1'b0;
    int   mdl_outst = 0, max_outst = 0, ret_cnt = 0, acc_cnt = 0;
    bit   s_req, s_ready, s_valid, s_pact;
    int   s_addr, s_outst, s_px, s_py, s_frame;

    function automatic int exp_pix(int x, int y);
        return (FB + y * W + x) & 'hFFF;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One pixel clock: drive inputs, record the handshake, advance past the edge.
    task automatic step();
        req_t r;
        pix_x      = 16'(beam_x);
        pix_y      = 16'(beam_y);
        pix_active = (beam_x < W) && (beam_y < H);
        rd_ready   = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(cyc % 2) : 1'b0;
        if (q.size() > 0 && q[0].due <= cyc) begin
            rd_valid = 1'b1;
            rd_data  = PW'(q[0].addr);
            void'(q.pop_front());
        end else begin
            rd_valid = 1'b0;
            rd_data  = PW'($urandom);
        end
        #1;
        s_req = rd_req; s_ready = rd_ready; s_valid = rd_valid; s_addr = int'(rd_addr);
        s_outst = mdl_outst; s_px = beam_x; s_py = beam_y; s_pact = pix_active; s_frame = frame;
        if (rd_req && rd_ready) begin
            r.addr = int'(rd_addr);
            r.due  = cyc + lat;
            q.push_back(r);
            acc_cnt++;
            mdl_outst++;
        end
        if (rd_valid) begin
            ret_cnt++;
            if (mdl_outst > 0) mdl_outst--;
        end
        if (mdl_outst > max_outst) max_outst = mdl_outst;
        @(posedge clk);
        cyc++;
        if (beam_run) begin
            beam_x++;
            if (beam_x == HT) begin
                beam_x = 0;
                beam_y++;
                if (beam_y == VT) begin
                    beam_y = 0;
                    frame++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        beam_run = 1'b0; beam_x = W + 1; beam_y = 0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        q.delete();
        mdl_outst = 0; max_outst = 0; ret_cnt = 0; acc_cnt = 0;
    endtask

    task automatic trig(int x, int y);
        beam_run = 1'b0; beam_x = x; beam_y = y;
        acc_cnt = 0; ret_cnt = 0; max_outst = 0;
        step();
        beam_x = W + 1;
    endtask

    // mode 1: pixels follow the framebuffer; mode 2: pixels must be black.
    task automatic run_to(string tag, int x, int y, int mode);
        int n = 0;
        while (!(beam_x == x && beam_y == y) && n < 5000) begin
            step();
            n++;
            if (s_pact && mode == 1) chk({tag, "_pix"}, int'(pix_out), exp_pix(s_px, s_py));
            if (s_pact && mode == 2) chk({tag, "_black"}, int'(pix_out), 0);
        end
    endtask

    task automatic show_line(string tag, int line);
        for (int x = 0; x < W; x++) begin
            beam_x = x; beam_y = line;
            step();
            chk({tag, "_pix"}, int'(pix_out), exp_pix(x, line));
        end
        beam_x = W + 1;
    endtask

    task automatic fetch_and_check(string tag, int y, int exp_max);
        int line, n, p_addr, ret_before, acc_before;
        int hold_bad, full_bad, seq_bad;
        bit p_stall, last_valid;
        line = (y == VT - 1) ? 0 : y + 1;
        hold_bad = 0; full_bad = 0; seq_bad = 0; p_stall = 0; p_addr = 0;
        ret_before = 0; last_valid = 0; n = 0;
        trig(0, y);
        chk({tag, "_busy_start"}, int'(busy), 1);
        while (busy && n < 400) begin
            ret_before = ret_cnt;
            acc_before = acc_cnt;
            step();
            n++;
            if (p_stall && (!s_req || s_addr != p_addr)) hold_bad++;
            if (s_outst >= MO && s_req) full_bad++;
            if (acc_cnt != acc_before && s_addr != FB + line * W + acc_before) seq_bad++;
            p_stall = s_req && !s_ready;
            p_addr = s_addr;
            last_valid = s_valid;
        end
        chk({tag, "_busy_fall"}, int'(busy), 0);
        chk({tag, "_returns"}, ret_cnt, W);
        chk({tag, "_accepts"}, acc_cnt, W);
        chk({tag, "_fall_on_last"}, int'(last_valid && ret_before == W - 1), 1);
        chk({tag, "_addr_hold_bad"}, hold_bad, 0);
        chk({tag, "_req_at_full_bad"}, full_bad, 0);
        chk({tag, "_addr_seq_bad"}, seq_bad, 0);
        chk({tag, "_max_outst"}, max_outst, exp_max);
        show_line(tag, line);
    endtask

    initial begin
        vec_t vecs[8];
        int n, bad, late;
        vecs[0] = '{0, 0, 1'b1, 'h110};
        vecs[1] = '{0, 3, 1'b1, 'h140};
        vecs[2] = '{0, 4, 1'b1, 'h150};
        vecs[3] = '{0, 5, 1'b0, 0};
        vecs[4] = '{0, 6, 1'b0, 0};
        vecs[5] = '{0, 7, 1'b0, 0};
        vecs[6] = '{0, 8, 1'b1, 'h100};
        vecs[7] = '{1, 2, 1'b0, 0};

        @(negedge clk);
        do_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd_req", int'(rd_req), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_pix_out", int'(pix_out), 0);
        chk("rst_underrun", int'(underrun_err), 0);
        chk("rst_overrun", int'(overrun_err), 0);

        // Trigger points and first fetch address.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            rmode = 2;
            trig(vecs[i].x, vecs[i].y);
            chk($sformatf("trig%0d_busy", i), int'(busy), int'(vecs[i].busy));
            chk($sformatf("trig%0d_rd_req", i), int'(rd_req), int'(vecs[i].busy));
            if (vecs[i].busy) chk($sformatf("trig%0d_rd_addr", i), int'(rd_addr), vecs[i].addr);
        end

        // Two frames from power-up: first line 0 is an underrun, frame 2 is all correct.
        do_reset();
        lat = 1; rmode = 0; frame = 0; beam_x = 0; beam_y = 0; beam_run = 1'b1;
        step();
        chk("a_line0_underrun", int'(underrun_err), 1);
        chk("a_line0_black", int'(pix_out), 0);
        n = 0;
        while (!(frame == 2 && beam_y == 1 && beam_x == 6) && n < 3000) begin
            step();
            n++;
            if (s_frame >= 1 && s_pact) chk("a_pix", int'(pix_out), exp_pix(s_px, s_py));
        end
        chk("a_overrun", int'(overrun_err), 0);
        chk("a_busy_midfetch", int'(busy), 1);
        reset = 1'b0;
        #1;
        chk("a_rst_pix_out", int'(pix_out), 0);
        chk("a_rst_busy", int'(busy), 0);
        chk("a_rst_rd_req", int'(rd_req), 0);
        chk("a_rst_rd_addr", int'(rd_addr), 0);
        chk("a_rst_underrun", int'(underrun_err), 0);

        // Slow stalling memory, then a long-latency memory that saturates the window.
        do_reset();
        lat = 3; rmode = 1;
        fetch_and_check("b", 1, 2);
        do_reset();
        lat = 6; rmode = 0;
        fetch_and_check("c", VT - 1, MO);

        // Memory stalled for a whole line.
        do_reset();
        lat = 1; rmode = 0; frame = 0; beam_x = 0; beam_y = VT - 1; beam_run = 1'b1;
        run_to("d_pre", 0, 2, 1);
        chk("d_underrun_clean", int'(underrun_err), 0);
        chk("d_overrun_clean", int'(overrun_err), 0);
        rmode = 2;
        run_to("d_line2", 0, 3, 1);
        chk("d_overrun_before", int'(overrun_err), 0);
        step();
        chk("d_overrun_set", int'(overrun_err), 1);
        chk("d_underrun_set", int'(underrun_err), 1);
        chk("d_line3_black0", int'(pix_out), 0);
        run_to("d_line3", W, 3, 2);

        // Reset in the middle of a fetch with reads still in flight.
        do_reset();
        lat = 6; rmode = 0;
        trig(0, 0);
        n = 0;
        while (acc_cnt < 10 && n < 200) begin
            step();
            n++;
        end
        chk("e_issue10", acc_cnt, 10);
        reset = 1'b0;
        #1;
        chk("e_rst_busy", int'(busy), 0);
        chk("e_rst_rd_req", int'(rd_req), 0);
        chk("e_rst_rd_addr", int'(rd_addr), 0);
        step();
        reset = 1'b1;
        mdl_outst = 0; bad = 0; late = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (busy || s_req) bad++;
            if (s_valid) late++;
        end
        chk("e_idle_after_release", bad, 0);
        chk("e_late_returns_seen", int'(late > 0), 1);
        lat = 1;
        trig(0, 0);
        chk("e_refetch_addr", int'(rd_addr), FB + W);
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk("e_refetch_done", int'(busy), 0);
        chk("e_refetch_returns", ret_cnt, W);
        show_line("e", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
